alu_serial: RTL and testbench
=============================

// Module: alu_serial
// PURPOSE
//  Multicycle digit-serial ALU: successor to the combinational 1-bit ALU cell, generalised to WIDTH bits.
//  Processes DIGIT bits per clock, LSB first, through one shared carry chain; start/busy/done handshake.
//  Sits in the multicycle datapath as the EX-stage unit; the control FSM waits on done.
//  Same opcode map as the 1-bit cell, plus status flags: zero, negative, signed overflow.
// PARAMETERS
//  WIDTH  16  operand/result width; WIDTH % DIGIT == 0 required (elaboration error otherwise)
//  DIGIT  1   bits processed per cycle; N = WIDTH/DIGIT cycles per operation
// PORTS
//  clk     in   1      clock, rising edge
//  rst_n   in   1      asynchronous active-low reset
//  start   in   1      request; sampled only when busy==0
//  ALUop   in   3      0 mov, 1 not, 2 add, 3 sub, 4 or, 5 and, 6 xor, 7 reserved
//  a       in   WIDTH  operand A
//  b       in   WIDTH  operand B
//  c_in    in   1      carry into LSB for add/sub
//  busy    out  1      operation in progress
//  done    out  1      one-cycle pulse: result/flags updated this cycle
//  result  out  WIDTH  result register
//  c_out   out  1      carry out of MSB (add/sub only, else 0)
//  zero    out  1      result == 0
//  neg     out  1      result[WIDTH-1]
//  ovf     out  1      signed overflow (add/sub only, else 0)
// BEHAVIOUR
//  - Reset (async, rst_n=0): state IDLE; busy, done, result, c_out, zero, neg, ovf, counter, shift regs = 0.
//  - FSM: IDLE --start--> RUN --(cnt==N-1)--> IDLE. start ignored while RUN (no queueing).
//  - Accept edge: on a clk edge with busy==0 && start==1, latch a, b, ALUop; carry reg <= c_in; cnt <= 0; busy=1 next cycle.
//  - Per RUN edge: take low DIGIT bits of A/B shift regs, compute DIGIT result bits, shift result in at MSB end,
//    shift A/B right by DIGIT; carry reg <= carry out of digit; cnt++.
//  - Digit ops: mov=a, not=~a, add=a+b+carry, sub=a+~b+carry, or, and, xor; op 7 -> 0 bits, carry held 0.
//  - sub is a + ~b + c_in: c_in=1 gives plain A-B; c_out=1 means no borrow.
//  - Completion: on the edge processing digit N-1: result, c_out, zero, neg, ovf update; done=1 and busy=0 for the
//    following cycle. Latency: start sampled at edge 0 -> done high in the cycle after edge N.
//  - ovf = carry into MSB XOR carry out of MSB, ops 2/3 only; c_out=0 and ovf=0 for all other ops.
//  - result/flags hold their values between completions; not cleared at start.
//  - Back-to-back: start high during the done cycle (busy=0) is accepted; done drops next cycle.
//  - Operand/ALUop changes during RUN have no effect (latched copies used).
//  - Reset mid-operation aborts immediately; no done pulse; outputs return to reset values.
//  - Arithmetic mod 2^WIDTH; no saturation.
// TESTING
//  1 WIDTH=16,DIGIT=1: add 0x7FFF+0x0001,c_in=0 -> done after 16 cycles; result 0x8000, ovf=1, neg=1, c_out=0, zero=0.
//  2 add 0xFFFF+0x0001,c_in=0 -> result 0x0000, zero=1, c_out=1, ovf=0; sub 0x0005-0x0007,c_in=1 -> 0xFFFE, c_out=0, neg=1.
//  3 WIDTH=16,DIGIT=4: and 0xF0F0&0x3C3C=0x3030; xor -> 0xCCCC; not a=0x00FF -> 0xFF00; mov 0x1234; done 4 cycles after start.
//  4 start pulsed again mid-RUN with new operands -> ignored; single done; result from first operands.
//  5 rst_n low at RUN cycle 7 -> busy/done/result/flags 0 at once, no done; a new start after release completes normally.
//  6 start held during done cycle with sub 0x0010-0x0001,c_in=1 -> accepted; done 16 cycles later; result 0x000F, c_out=1; op 7 -> result 0, c_out=0.

Source files
------------

// File: rtl/alu_serial.sv
// Digit-serial ALU: WIDTH-bit operands processed DIGIT bits per clock, LSB first,
// through one shared carry chain. start/busy/done handshake; result and status
// flags are registered and hold between completions.
module alu_serial #(
  parameter int WIDTH = 16,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       ALUop,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             c_out,
  output logic             zero,
  output logic             neg,
  output logic             ovf
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned TOP = DIGIT - 1;

  // Operand width must split into whole digits.
  if (WIDTH % DIGIT != 0) begin : g_bad_digit
    $error("alu_serial: WIDTH must be a multiple of DIGIT");
  end

  typedef enum logic [0:0] {IDLE, RUN} state_t;

  typedef enum logic [2:0] {
    OP_MOV = 3'd0,
    OP_NOT = 3'd1,
    OP_ADD = 3'd2,
    OP_SUB = 3'd3,
    OP_OR  = 3'd4,
    OP_AND = 3'd5,
    OP_XOR = 3'd6,
    OP_RSV = 3'd7
  } op_t;

  state_t           state;
  op_t              op_r;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] acc;
  logic             carry_r;
  logic [CW-1:0]    cnt;

  logic [DIGIT-1:0]       dig_res;
  logic                   carry_nx;
  logic                   c_msb;
  logic [WIDTH+DIGIT-1:0] acc_cat;
  logic [WIDTH-1:0]       acc_nx;
  logic                   is_arith;
  logic                   last;

  assign is_arith = (op_r == OP_ADD) || (op_r == OP_SUB);
  assign last     = (cnt == CW'(N - 1));

  // One digit through the shared carry chain; c_msb captures the carry into the
  // top bit of the digit, which on the final digit is the carry into the MSB.
  always_comb begin : digit_calc
    logic c;
    logic ai;
    logic bi;
    dig_res = '0;
    c_msb   = 1'b0;
    c       = carry_r;
    for (int unsigned i = 0; i < DIGIT; i++) begin
      ai = a_sr[i];
      bi = b_sr[i];
      if (i == TOP) c_msb = c;
      unique case (op_r)
        OP_MOV: dig_res[i] = ai;
        OP_NOT: dig_res[i] = ~ai;
        OP_ADD: begin
          dig_res[i] = ai ^ bi ^ c;
          c          = (ai & bi) | (c & (ai ^ bi));
        end
        OP_SUB: begin
          dig_res[i] = ai ^ ~bi ^ c;
          c          = (ai & ~bi) | (c & (ai ^ ~bi));
        end
        OP_OR:  dig_res[i] = ai | bi;
        OP_AND: dig_res[i] = ai & bi;
        OP_XOR: dig_res[i] = ai ^ bi;
        default: begin
          dig_res[i] = 1'b0;
          c          = 1'b0;
        end
      endcase
    end
    carry_nx = c;
  end

  // New digit enters at the MSB end; written as a shift of the concatenation so
  // DIGIT == WIDTH needs no special case.
  always_comb begin
    acc_cat = {dig_res, acc} >> DIGIT;
    acc_nx  = acc_cat[WIDTH-1:0];
  end

  // Control FSM with registered handshake, shift registers and result/flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      op_r    <= OP_MOV;
      a_sr    <= '0;
      b_sr    <= '0;
      acc     <= '0;
      carry_r <= 1'b0;
      cnt     <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      result  <= '0;
      c_out   <= 1'b0;
      zero    <= 1'b0;
      neg     <= 1'b0;
      ovf     <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            op_r    <= op_t'(ALUop);
            a_sr    <= a;
            b_sr    <= b;
            carry_r <= ((ALUop == OP_ADD) || (ALUop == OP_SUB)) ? c_in : 1'b0;
            cnt     <= '0;
            busy    <= 1'b1;
            state   <= RUN;
          end
        end
        RUN: begin
          a_sr    <= a_sr >> DIGIT;
          b_sr    <= b_sr >> DIGIT;
          acc     <= acc_nx;
          carry_r <= carry_nx;
          cnt     <= cnt + CW'(1);
          if (last) begin
            state  <= IDLE;
            busy   <= 1'b0;
            done   <= 1'b1;
            result <= acc_nx;
            zero   <= (acc_nx == '0);
            neg    <= acc_nx[WIDTH-1];
            c_out  <= is_arith & carry_nx;
            ovf    <= is_arith & (c_msb ^ carry_nx);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_serial.sv
// Directed bench for alu_serial: a DIGIT=1 and a DIGIT=4 instance share clock
// and reset; each scenario task checks its own expected values inline.
module tb_alu_serial;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        s1 = 1'b0, ci1 = 1'b0;
  logic [2:0]  op1 = '0;
  logic [15:0] a1 = '0, b1 = '0;
  logic        busy1, done1, co1, z1, n1, v1;
  logic [15:0] res1;

  logic        s4 = 1'b0, ci4 = 1'b0;
  logic [2:0]  op4 = '0;
  logic [15:0] a4 = '0, b4 = '0;
  logic        busy4, done4, co4, z4, n4, v4;
  logic [15:0] res4;

  int total = 0;
  int passed = 0;

  alu_serial #(.WIDTH(16), .DIGIT(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(s1), .ALUop(op1), .a(a1), .b(b1), .c_in(ci1),
    .busy(busy1), .done(done1), .result(res1), .c_out(co1), .zero(z1), .neg(n1), .ovf(v1)
  );

  alu_serial #(.WIDTH(16), .DIGIT(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(s4), .ALUop(op4), .a(a4), .b(b4), .c_in(ci4),
    .busy(busy4), .done(done4), .result(res4), .c_out(co4), .zero(z4), .neg(n4), .ovf(v4)
  );

  // Issue one op on dut1, scramble inputs after acceptance, return cycles to done (-1 on timeout).
  task automatic go1(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                     input logic ci, output int lat);
    @(posedge clk); #1;
    op1 = op; a1 = a; b1 = b; ci1 = ci; s1 = 1'b1;
    @(posedge clk); #1;
    s1 = 1'b0; a1 = ~a; b1 = ~b; op1 = ~op; ci1 = ~ci;
    lat = -1;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      if (done1) begin lat = k; break; end
    end
  endtask

  task automatic go4(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                     input logic ci, output int lat);
    @(posedge clk); #1;
    op4 = op; a4 = a; b4 = b; ci4 = ci; s4 = 1'b1;
    @(posedge clk); #1;
    s4 = 1'b0; a4 = ~a; b4 = ~b; op4 = ~op;
    lat = -1;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      if (done4) begin lat = k; break; end
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if ({busy1, done1, res1, co1, z1, n1, v1} !== 22'd0) $display("FAIL reset_dut1 got %h required 0", {busy1, done1, res1, co1, z1, n1, v1});
    else passed++;
    total++;
    if ({busy4, done4, res4, co4, z4, n4, v4} !== 22'd0) $display("FAIL reset_dut4 got %h required 0", {busy4, done4, res4, co4, z4, n4, v4});
    else passed++;
    rst_n = 1'b1;
  endtask

  task automatic test_add;
    int lat;
    go1(3'd2, 16'h7FFF, 16'h0001, 1'b0, lat);
    total++;
    if (lat !== 16) $display("FAIL add_ovf_latency got %0d required 16", lat); else passed++;
    total++;
    if ({res1, co1, z1, n1, v1} !== {16'h8000, 4'b0011})
      $display("FAIL add_ovf got res=%h c=%b z=%b n=%b v=%b required res=8000 c=0 z=0 n=1 v=1", res1, co1, z1, n1, v1);
    else passed++;
    total++;
    if (busy1 !== 1'b0) $display("FAIL add_ovf_busy got %b required 0", busy1); else passed++;
    go1(3'd2, 16'hFFFF, 16'h0001, 1'b0, lat);
    total++;
    if ({res1, co1, z1, n1, v1} !== {16'h0000, 4'b1100})
      $display("FAIL add_wrap got res=%h c=%b z=%b n=%b v=%b required res=0000 c=1 z=1 n=0 v=0", res1, co1, z1, n1, v1);
    else passed++;
    go1(3'd3, 16'h0005, 16'h0007, 1'b1, lat);
    total++;
    if ({res1, co1, z1, n1, v1} !== {16'hFFFE, 4'b0010})
      $display("FAIL sub_borrow got res=%h c=%b z=%b n=%b v=%b required res=fffe c=0 z=0 n=1 v=0", res1, co1, z1, n1, v1);
    else passed++;
  endtask

  task automatic test_digit4;
    int lat;
    go4(3'd5, 16'hF0F0, 16'h3C3C, 1'b1, lat);
    total++;
    if (lat !== 4) $display("FAIL d4_latency got %0d required 4", lat); else passed++;
    total++;
    if ({res4, co4, z4, n4, v4} !== {16'h3030, 4'b0000})
      $display("FAIL d4_and got res=%h c=%b z=%b n=%b v=%b required res=3030 flags 0000", res4, co4, z4, n4, v4);
    else passed++;
    go4(3'd6, 16'hF0F0, 16'h3C3C, 1'b0, lat);
    total++;
    if ({res4, n4} !== {16'hCCCC, 1'b1}) $display("FAIL d4_xor got res=%h n=%b required res=cccc n=1", res4, n4); else passed++;
    go4(3'd1, 16'h00FF, 16'h1234, 1'b0, lat);
    total++;
    if ({res4, co4, n4} !== {16'hFF00, 1'b0, 1'b1}) $display("FAIL d4_not got res=%h c=%b n=%b required res=ff00 c=0 n=1", res4, co4, n4); else passed++;
    go4(3'd0, 16'h1234, 16'hFFFF, 1'b1, lat);
    total++;
    if ({res4, co4, z4, n4, v4} !== {16'h1234, 4'b0000})
      $display("FAIL d4_mov got res=%h c=%b z=%b n=%b v=%b required res=1234 flags 0000", res4, co4, z4, n4, v4);
    else passed++;
    go4(3'd2, 16'h8000, 16'h8000, 1'b0, lat);
    total++;
    if ({res4, co4, z4, n4, v4} !== {16'h0000, 4'b1101})
      $display("FAIL d4_add_ovf got res=%h c=%b z=%b n=%b v=%b required res=0000 c=1 z=1 n=0 v=1", res4, co4, z4, n4, v4);
    else passed++;
  endtask

  task automatic test_ignore_restart;
    int dones = 0;
    int first = -1;
    logic [15:0] cap = '0;
    @(posedge clk); #1;
    op1 = 3'd2; a1 = 16'h0003; b1 = 16'h0004; ci1 = 1'b0; s1 = 1'b1;
    @(posedge clk); #1;
    s1 = 1'b0;
    for (int k = 1; k <= 30; k++) begin
      @(posedge clk); #1;
      if (k == 5) begin s1 = 1'b1; op1 = 3'd6; a1 = 16'h1000; b1 = 16'h1000; end
      if (k == 6) s1 = 1'b0;
      if (done1) begin
        dones++;
        if (first < 0) begin first = k; cap = res1; end
      end
    end
    total++;
    if (dones !== 1) $display("FAIL ignore_done_count got %0d required 1", dones); else passed++;
    total++;
    if (first !== 16) $display("FAIL ignore_latency got %0d required 16", first); else passed++;
    total++;
    if (cap !== 16'h0007) $display("FAIL ignore_result got %h required 0007", cap); else passed++;
  endtask

  task automatic test_reset_mid;
    int dones = 0;
    int lat;
    @(posedge clk); #1;
    op1 = 3'd2; a1 = 16'h1111; b1 = 16'h2222; ci1 = 1'b0; s1 = 1'b1;
    @(posedge clk); #1;
    s1 = 1'b0;
    repeat (7) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    total++;
    if ({busy1, done1, res1, co1, z1, n1, v1} !== 22'd0)
      $display("FAIL reset_mid_outputs got %h required 0", {busy1, done1, res1, co1, z1, n1, v1});
    else passed++;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      if (done1 || busy1) dones++;
    end
    total++;
    if (dones !== 0) $display("FAIL reset_mid_no_done got %0d busy/done cycles required 0", dones); else passed++;
    go1(3'd2, 16'h0001, 16'h0002, 1'b0, lat);
    total++;
    if ({lat, res1} !== {32'd16, 16'h0003}) $display("FAIL reset_mid_restart got lat=%0d res=%h required lat=16 res=0003", lat, res1); else passed++;
  endtask

  task automatic test_back_to_back;
    int lat;
    int first = -1;
    go1(3'd6, 16'h00FF, 16'h0F0F, 1'b0, lat);
    total++;
    if (res1 !== 16'h0FF0) $display("FAIL b2b_first got %h required 0ff0", res1); else passed++;
    op1 = 3'd3; a1 = 16'h0010; b1 = 16'h0001; ci1 = 1'b1; s1 = 1'b1;
    @(posedge clk); #1;
    s1 = 1'b0;
    total++;
    if ({done1, busy1} !== 2'b01) $display("FAIL b2b_accept got done=%b busy=%b required done=0 busy=1", done1, busy1); else passed++;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      if (done1) begin first = k; break; end
    end
    total++;
    if (first !== 16) $display("FAIL b2b_latency got %0d required 16", first); else passed++;
    total++;
    if ({res1, co1, z1, n1, v1} !== {16'h000F, 4'b1000})
      $display("FAIL b2b_sub got res=%h c=%b z=%b n=%b v=%b required res=000f c=1 z=0 n=0 v=0", res1, co1, z1, n1, v1);
    else passed++;
    go1(3'd7, 16'hFFFF, 16'hFFFF, 1'b1, lat);
    total++;
    if ({res1, co1, z1, n1, v1} !== {16'h0000, 4'b0100})
      $display("FAIL op7 got res=%h c=%b z=%b n=%b v=%b required res=0000 c=0 z=1 n=0 v=0", res1, co1, z1, n1, v1);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_add();
    test_digit4();
    test_ignore_restart();
    test_reset_mid();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
